// File: rtl/dna_reader_if.sv
// dna_reader_if: host-side status/request signals plus the DNA_PORT strobe/data
// pins, bundled so the controller and its environment connect with one port.
// master = the dna_reader controller, slave = host logic / DNA_PORT side.
interface dna_reader_if #(
    parameter int DNA_WIDTH = 57
) ();
    logic                 start;
    logic                 busy;
    logic                 valid;
    logic [DNA_WIDTH-1:0] dna;
    logic                 dna_absent;
    logic                 dna_read;
    logic                 dna_shift;
    logic                 dna_din;
    logic                 dna_dout;

    modport master (
        input  start,
        input  dna_dout,
        output busy,
        output valid,
        output dna,
        output dna_absent,
        output dna_read,
        output dna_shift,
        output dna_din
    );

    modport slave (
        output start,
        output dna_dout,
        input  busy,
        input  valid,
        input  dna,
        input  dna_absent,
        input  dna_read,
        input  dna_shift,
        input  dna_din
    );
endinterface

// File: rtl/dna_reader.sv
// dna_reader: drives DNA_PORT READ/SHIFT, captures DOUT MSB-first into a
// DNA_WIDTH-bit word and presents it valid-qualified and stable.
// DIN loops back DOUT so a full read rotates the primitive back to its
// original contents; reads are repeatable.
// Optional macro DNA_READER_ABSENT_DETECT_EN: registers an all-zero flag on
// dna_absent at capture completion; without it dna_absent is tied low.
module dna_reader #(
    parameter int DNA_WIDTH  = 57,
    parameter bit AUTO_START = 1'b1
) (
    input logic          CLK,
    input logic          RST_N,
    dna_reader_if.master bus
);
    localparam int CW = (DNA_WIDTH > 1) ? $clog2(DNA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DNA_WIDTH-1:0] sr_q, sr_d;
    logic [DNA_WIDTH-1:0] dna_q, dna_d;
    logic                 valid_q, valid_d;
    logic                 auto_q, auto_d;
    logic [DNA_WIDTH-1:0] sr_shifted;
    logic                 last_bit;

    // Shift register with the incoming DOUT bit appended at the LSB
    if (DNA_WIDTH == 1) begin : g_w1
        assign sr_shifted = bus.dna_dout;
    end else begin : g_wn
        assign sr_shifted = {sr_q[DNA_WIDTH-2:0], bus.dna_dout};
    end

    assign last_bit = (cnt_q == CW'(DNA_WIDTH - 1));

    // Next-state: sequence IDLE/DONE -> LOAD -> SHIFT x DNA_WIDTH -> DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dna_d   = dna_q;
        valid_d = valid_q;
        auto_d  = 1'b0;   // auto-launch only ever applies to the first edge
        case (state_q)
            IDLE: begin
                if (bus.start || auto_q) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                sr_d = sr_shifted;
                if (last_bit) begin
                    // whole word lands at once so dna never shows a partial read
                    dna_d   = sr_shifted;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dna_q   <= '0;
            valid_q <= 1'b0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dna_q   <= dna_d;
            valid_q <= valid_d;
            auto_q  <= auto_d;
        end
    end

`ifdef DNA_READER_ABSENT_DETECT_EN
    logic absent_q, absent_d;

    // Zero-detect sampled together with dna at capture completion
    always_comb begin
        absent_d = absent_q;
        if (state_q == SHIFT && last_bit) absent_d = (sr_shifted == '0);
    end

    // Absent flag register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) absent_q <= 1'b0;
        else        absent_q <= absent_d;
    end

    assign bus.dna_absent = absent_q;
`else
    assign bus.dna_absent = 1'b0;
`endif

    // Strobes decoded from registered state only: no input-to-pin path
    assign bus.dna_read  = (state_q == LOAD);
    assign bus.dna_shift = (state_q == SHIFT);
    assign bus.busy      = (state_q == LOAD) || (state_q == SHIFT);
    assign bus.valid     = valid_q;
    assign bus.dna       = dna_q;
    assign bus.dna_din   = bus.dna_dout;
endmodule
